// File: rtl/pipe_pkg.sv
// pipe_pkg: stage bundle typedefs, stage state enum and stall counter width default
package pipe_pkg;
  localparam int PIPE_CNT_W = 32;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_e;
  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] br_op;
    logic [2:0] imm_sel;
    logic [1:0] mem_size;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic [1:0] wb_sel;
  } controlsgs_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_bundle_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    controlsgs_t ctrl;
  } id_ex_bundle_t;
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [31:0] pc4;
    controlsgs_t ctrl;
  } ex_mem_bundle_t;
  typedef struct packed {
    logic [31:0] wb_val;
    logic [31:0] pc4;
    controlsgs_t ctrl;
  } mem_wb_bundle_t;
  localparam int IF_ID_W  = $bits(if_id_bundle_t);
  localparam int ID_EX_W  = $bits(id_ex_bundle_t);
  localparam int EX_MEM_W = $bits(ex_mem_bundle_t);
  localparam int MEM_WB_W = $bits(mem_wb_bundle_t);
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry skid register with its valid bit
module pipe_skid_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush and saturating stall counter;
// defining PIPE_STAGE_SKID_EN adds a one-entry skid buffer and a registered in_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_e      state, state_nxt;
  logic             xfer_in, xfer_out, load_main;
  logic [WIDTH-1:0] main_nxt;
  assign out_valid = state != EMPTY;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  assign in_ready = !skid_valid;
  pipe_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (!flush && state == FULL && xfer_in && !out_ready),
    .drain (state == SKID && out_ready),
    .clear (flush),
    .d     (in_data),
    .valid (skid_valid),
    .q     (skid_data)
  );
  always_comb begin
    state_nxt = flush ? EMPTY
              : state == EMPTY ? (xfer_in ? FULL : EMPTY)
              : state == FULL ? (xfer_in && !out_ready ? SKID : xfer_out && !xfer_in ? EMPTY : FULL)
              : (out_ready ? FULL : SKID);
    load_main = !flush && (state == SKID ? out_ready : xfer_in && (state == EMPTY || out_ready));
    main_nxt  = state == SKID ? skid_data : in_data;
  end
`else
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    state_nxt = flush ? EMPTY : xfer_in ? FULL : xfer_out ? EMPTY : state;
    load_main = !flush && xfer_in;
    main_nxt  = in_data;
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) out_data <= main_nxt;
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic [3:0]  stall_cnt;

  pipe_stage_reg #(.WIDTH(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int          nchk = 0, npass = 0, nfail = 0;
  logic [31:0] held[$];
  logic [31:0] sb[$];
  logic [31:0] exp_data = '0;
  int          cnt = 0, delivered = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    assert (obs === expv) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic m_in_ready(input logic r);
`ifdef PIPE_STAGE_SKID_EN
    return held.size() < 2;
`else
    return held.size() == 0 || r;
`endif
  endfunction

  task automatic model_reset();
    held.delete();
    sb.delete();
    cnt = 0;
    exp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic        rdy, mov, dov, dir;
    logic [31:0] dod, want;
    in_valid = v;
    in_data = v ? d : 'x;
    out_ready = r;
    flush = f;
    #1;
    rdy = m_in_ready(r);
    mov = held.size() != 0;
    chk("in_ready", in_ready, rdy);
    dov = out_valid;
    dod = out_data;
    dir = in_ready;
    @(posedge clk);
    if (dov && r) begin
      delivered++;
      if (sb.size() == 0) chk("sb_spurious", 1, 0);
      else begin
        want = sb.pop_front();
        chk("sb_order", dod, want);
      end
    end
    if (f) sb.delete();
    else if (v && dir) sb.push_back(d);
    if (mov && !r) cnt = cnt == 15 ? 15 : cnt + 1;
    if (f) held.delete();
    else begin
      if (mov && r) void'(held.pop_front());
      if (v && rdy) held.push_back(d);
    end
    if (held.size() != 0) exp_data = held[0];
    #1;
    chk("out_valid", out_valid, held.size() != 0);
    chk("out_data", out_data, exp_data);
    chk("stall_cnt", stall_cnt, cnt);
  endtask

  initial begin
    logic v, r;
    int   acc;
    do_reset();
    // stream 1,2,3 at full throughput
    cyc(1, 32'h1, 1, 0);
    chk("stream_1", out_data, 32'h1);
    cyc(1, 32'h2, 1, 0);
    chk("stream_2", out_data, 32'h2);
    cyc(1, 32'h3, 1, 0);
    chk("stream_3", out_data, 32'h3);
    chk("stream_valid", out_valid, 1);
    cyc(0, 0, 1, 0);
    // backpressure
    cyc(1, 32'hA5, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'hB6, 0, 0);
    chk("bp_data", out_data, 32'hA5);
    chk("bp_cnt", stall_cnt, 4);
    cyc(0, 0, 1, 0);
`ifdef PIPE_STAGE_SKID_EN
    chk("bp_skid_out", out_data, 32'hB6);
`endif
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    // flush while FULL, then while SKID (FULL-with-stall in base mode)
    cyc(1, 32'h11, 1, 0);
    cyc(1, 32'hCC, 1, 1);
    chk("flush_full_valid", out_valid, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h22, 1, 0);
    cyc(1, 32'h33, 0, 0);
    cyc(1, 32'hCC, 1, 1);
    chk("flush_skid_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    // saturation
    do_reset();
    cyc(1, 32'h5A, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
    chk("sat_15", stall_cnt, 15);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("sat_hold", stall_cnt, 15);
    // asynchronous reset mid-stall
    do_reset();
    cyc(1, 32'h77, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    chk("pre_async_cnt", stall_cnt, 7);
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    chk("async_cnt", stall_cnt, 0);
    model_reset();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    // random traffic, 1000 payloads
    acc = 0;
    delivered = 0;
    for (int i = 0; i < 20000 && delivered < 1000; i++) begin
      v = acc < 1000 && $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      if (v && m_in_ready(r)) acc++;
      cyc(v, $urandom, r, 0);
    end
    chk("rand_delivered", delivered, 1000);
    chk("rand_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register; successor to the fixed-width decode/execute register.
- Carries an opaque WIDTH-bit payload (packed stage bundle) between any two core stages.
- Adds a valid/ready handshake, synchronous flush (bubble insertion), a stall-cycle counter and an optional skid buffer.
- Instantiated between fetch/decode, decode/execute, execute/memory and memory/writeback.

Parameters:
- WIDTH, 128, payload width in bits; normally $bits of the stage bundle typedef.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream payload valid
- in_ready  out  1  this stage can accept in_data this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  out_data holds a live payload
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  registered payload
- flush  in  1  synchronous kill of all held payloads (branch/trap redirect)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset, asynchronous: out_valid=0, out_data='0, stall_cnt=0, skid empty. in_ready is 1 from the first cycle after reset deasserts.
- Transfer in: occurs on a rising edge with in_valid && in_ready.
- Transfer out: occurs on a rising edge with out_valid && out_ready.
- Latency: payload accepted at edge N appears on out_data with out_valid=1 after edge N; one-cycle latency.
- out_data changes only on a transfer in or a refill from skid. It is held stable while out_valid && !out_ready.
- Payload contents are never inspected or modified.
- Base mode (no skid), states EMPTY and FULL:
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
  - EMPTY -> FULL on transfer in.
  - FULL -> FULL on simultaneous transfer out and transfer in (back-to-back, full throughput).
  - FULL -> EMPTY on transfer out without transfer in.
  - FULL holds while !out_ready.
- Flush:
  - Next edge: out_valid=0 and skid cleared; state becomes EMPTY.
  - A transfer in occurring in the same cycle is discarded. in_ready is still reported normally, so upstream treats it as consumed.
  - out_data is left unchanged (don't-care when invalid).
  - Flush has priority over every other event.
- stall_cnt:
  - Increments on every edge where out_valid && !out_ready.
  - Saturates at all-ones; does not wrap.
  - Not cleared by flush; cleared only by reset.
- in_data is sampled only on transfer in. X on in_data while !in_valid must not propagate to out_data.
- Reset asserted mid-transfer: all state clears immediately, independent of clk.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: a one-entry skid buffer is added and in_ready becomes a registered output (no combinational out_ready -> in_ready path).
  - in_ready = !skid_valid.
  - States: EMPTY, FULL (main only), SKID (main + skid).
  - FULL + transfer in + !out_ready -> SKID (payload captured in skid).
  - SKID + out_ready -> FULL, with main refilled from skid on the same edge.
  - In SKID, in_ready=0.
  - Throughput remains 1 per cycle; latency unchanged at 1.
- Undefined: base mode only, with no skid storage synthesised.

Decomposition:
- Shared package pipe_pkg:
  - stage bundle typedefs per boundary (e.g. id_ex_bundle_t = instr, pc, pc4, controlsgs_t), so WIDTH = $bits(id_ex_bundle_t);
  - state enum pipe_state_e {EMPTY, FULL, SKID};
  - CNT_W default constant.
- One natural sub-module: pipe_skid_buf, holding the skid entry and its valid bit; instantiated only under PIPE_STAGE_SKID_EN.

Test Plan:
- Reset then stream: in_valid=1 with in_data=0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each; out_valid continuous; stall_cnt=0.
- Backpressure: load 0xA5, hold out_ready=0 for 4 cycles -> out_data stays 0xA5, out_valid=1, stall_cnt=4. Base mode: in_ready=0 throughout. Skid mode: 0xB6 is accepted into skid, then in_ready=0; on release 0xA5 then 0xB6 emerge on consecutive cycles.
- Flush while FULL (and SKID when skid enabled), with a simultaneous in_valid=1 of 0xCC -> next cycle out_valid=0; 0xCC never appears on the output; stall_cnt unchanged.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15 and remains 15.
- Async reset pulse mid-stall (out_valid=1, stall_cnt=7), between clock edges -> out_valid=0, out_data=0, stall_cnt=0 immediately, before the next edge.
- Random valid/ready toggling with 1000 payloads -> scoreboard shows in-order, lossless, duplicate-free delivery; out_data stable whenever out_valid && !out_ready.
